// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment display arbiter.
//   seg7_state_e  : arbiter FSM states (IDLE / OWN / LINGER)
//   SEG7_DIGITS   : digits on the display
//   SEG7_NIBBLE_W : bits per digit
//   SEG7_VALUE_W  : full display value width
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    LINGER = 2'd2
  } seg7_state_e;

  localparam int SEG7_DIGITS   = 8;
  localparam int SEG7_NIBBLE_W = 4;
  localparam int SEG7_VALUE_W  = SEG7_DIGITS * SEG7_NIBBLE_W;

endpackage

// File: rtl/seg7_rr_pick.sv
// seg7_rr_pick: combinational round-robin picker.
//   i_req    : request vector
//   i_ptr    : index of the last winner; search starts at i_ptr+1 and wraps
//   i_excl   : requesters to ignore in this pick
//   o_onehot : one-hot winner (all zero when nothing eligible)
//   o_idx    : winner index
//   o_valid  : an eligible requester was found
module seg7_rr_pick
  import seg7_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  input  logic [NUM_REQ-1:0]         i_excl,
  output logic [NUM_REQ-1:0]         o_onehot,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_cand;

  assign w_cand = i_req & ~i_excl;

  always_comb begin
    int   cand_idx;
    logic found;
    cand_idx = 0;
    found    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    // The pointer itself is visited last, giving the previous winner lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = (int'(i_ptr) + i) % NUM_REQ;
      if (!found && w_cand[cand_idx]) begin
        found = 1'b1;
        o_idx = IW'(cand_idx);
      end
    end
    if (found) o_onehot[o_idx] = 1'b1;
    o_valid = found;
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: shares one 8-digit seven-segment display between
// NUM_REQ requesters with request/grant handshake and round-robin fairness.
// After the owner releases, its last value stays on the display for
// LINGER_CYCLES cycles before the scan driver is blanked.
//
// Optional feature macro: SEG7_ARB_PREEMPT_EN
//   defined   : an owner that has held the display for MAX_HOLD cycles is
//               preempted when another requester is waiting.
//   undefined : no tenure tracking; owner keeps the display until release.
//
// Ports:
//   clk_i    : system clock
//   rst_n    : asynchronous active-low reset
//   req_i    : per-requester level request
//   data_i   : per-requester 32-bit value, requester k at [32k+31:32k]
//   grant_o  : one-hot grant (registered)
//   owner_o  : index of current / last owner (registered)
//   num_o    : value to scan driver (registered)
//   blank_o  : active-high blank to scan driver (registered)
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int LINGER_CYCLES = 1000,
  parameter int MAX_HOLD      = 50_000_000
) (
  input  logic                              clk_i,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ*SEG7_VALUE_W-1:0]   data_i,
  output logic [NUM_REQ-1:0]                grant_o,
  output logic [$clog2(NUM_REQ)-1:0]        owner_o,
  output logic [SEG7_VALUE_W-1:0]           num_o,
  output logic                              blank_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int LW = (LINGER_CYCLES > 0) ? $clog2(LINGER_CYCLES + 1) : 1;
  localparam logic [LW-1:0] LINGER_LAST = LW'((LINGER_CYCLES > 0) ? LINGER_CYCLES - 1 : 0);

  seg7_state_e             r_state, w_state_nxt;
  logic [NUM_REQ-1:0]      r_grant, w_grant_nxt;
  logic [IW-1:0]           r_owner, w_owner_nxt;
  logic [IW-1:0]           r_ptr,   w_ptr_nxt;
  logic [SEG7_VALUE_W-1:0] r_num,   w_num_nxt;
  logic                    r_blank, w_blank_nxt;
  logic [LW-1:0]           r_lcnt,  w_lcnt_nxt;

  logic [SEG7_VALUE_W-1:0] w_data [NUM_REQ];
  logic [NUM_REQ-1:0]      w_excl;
  logic [NUM_REQ-1:0]      w_win_onehot;
  logic [IW-1:0]           w_win_idx;
  logic                    w_win_valid;

`ifdef SEG7_ARB_PREEMPT_EN
  localparam int TW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [TW-1:0] HOLD_LIMIT = TW'(MAX_HOLD);
  logic [TW-1:0] r_tenure, w_tenure_nxt;
`else
  logic w_unused_max_hold;
  assign w_unused_max_hold = (MAX_HOLD > 0);
`endif

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_data
    assign w_data[k] = data_i[SEG7_VALUE_W*k +: SEG7_VALUE_W];
  end

  // While owning, the owner is never a candidate: on release its request is
  // already low, and on preemption it must be skipped.
  assign w_excl = (r_state == OWN) ? r_grant : '0;

  seg7_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .i_excl   (w_excl),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_num_nxt   = r_num;
    w_blank_nxt = r_blank;
    w_lcnt_nxt  = r_lcnt;
`ifdef SEG7_ARB_PREEMPT_EN
    w_tenure_nxt = r_tenure;
`endif

    unique case (r_state)
      IDLE: begin
        if (w_win_valid) w_state_nxt = OWN;
      end
      OWN: begin
        if (!req_i[r_owner]) begin
          if (!w_win_valid) begin
            w_grant_nxt = '0;
            if (LINGER_CYCLES == 0) begin
              w_state_nxt = IDLE;
              w_blank_nxt = 1'b1;
            end else begin
              w_state_nxt = LINGER;
              w_lcnt_nxt  = '0;
            end
          end
`ifdef SEG7_ARB_PREEMPT_EN
        end else if (!(r_tenure == HOLD_LIMIT && w_win_valid)) begin
          w_num_nxt = w_data[r_owner];
          if (r_tenure != HOLD_LIMIT) w_tenure_nxt = r_tenure + TW'(1);
`else
        end else begin
          w_num_nxt = w_data[r_owner];
`endif
        end
      end
      LINGER: begin
        if (!w_win_valid) begin
          if (r_lcnt == LINGER_LAST) begin
            w_state_nxt = IDLE;
            w_blank_nxt = 1'b1;
          end else begin
            w_lcnt_nxt = r_lcnt + LW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A new grant is due whenever arbitration runs and finds someone: from
    // IDLE/LINGER, on owner release, or on preemption.
    if (w_win_valid && (r_state != OWN || !req_i[r_owner]
`ifdef SEG7_ARB_PREEMPT_EN
                        || r_tenure == HOLD_LIMIT
`endif
                        )) begin
      w_state_nxt = OWN;
      w_grant_nxt = w_win_onehot;
      w_owner_nxt = w_win_idx;
      w_ptr_nxt   = w_win_idx;
      w_num_nxt   = w_data[w_win_idx];
      w_blank_nxt = 1'b0;
      w_lcnt_nxt  = '0;
`ifdef SEG7_ARB_PREEMPT_EN
      w_tenure_nxt = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_num   <= '0;
      r_blank <= 1'b1;
      r_lcnt  <= '0;
`ifdef SEG7_ARB_PREEMPT_EN
      r_tenure <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_num   <= w_num_nxt;
      r_blank <= w_blank_nxt;
      r_lcnt  <= w_lcnt_nxt;
`ifdef SEG7_ARB_PREEMPT_EN
      r_tenure <= w_tenure_nxt;
`endif
    end
  end

  assign grant_o = r_grant;
  assign owner_o = r_owner;
  assign num_o   = r_num;
  assign blank_o = r_blank;

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Shares the single 8-digit seven-segment display between several requesters (CPU register block, debug monitor, boot status, etc.) with a request/grant handshake and round-robin fairness. Sits directly upstream of the seven-segment scan driver: drives its 32-bit hex value and its active-high blank/reset input. It also keeps the last value on the display for a configurable linger time after release, so short-lived owners remain readable.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- LINGER_CYCLES, 1000, cycles the last value stays displayed after release (0 allowed)
- MAX_HOLD, 50_000_000, owner tenure limit before preemption (used only with SEG7_ARB_PREEMPT_EN)

- clk_i  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester display request, level, held while display is wanted
- data_i  in  NUM_REQ*32  per-requester 8-nibble value, requester k at [32k+31:32k]
- grant_o  out  NUM_REQ  one-hot grant, registered
- owner_o  out  $clog2(NUM_REQ)  index of current/last owner
- num_o  out  32  value to scan driver, registered
- blank_o  out  1  active-high blank to scan driver reset input

## Operation
- Reset values: grant_o=0, owner_o=0, num_o=0, blank_o=1, state IDLE, rr pointer=NUM_REQ-1, counters 0.
- States: IDLE, OWN, LINGER.
- IDLE: blank_o=1, grant_o=0. Any req_i bit set → pick winner, go OWN.
- Winner pick: round-robin, search from pointer+1 upward with wrap-around; pointer ← winner on every grant. After reset, requester 0 has top priority.
- OWN: grant_o = onehot(owner), blank_o=0, num_o ← data_i[owner] every cycle (live tracking). tenure counter increments, saturating at MAX_HOLD.
- OWN, req_i[owner] low → LINGER: grant_o=0, num_o frozen, blank_o stays 0, linger counter cleared. If LINGER_CYCLES=0, go to IDLE instead.
- LINGER: linger counter increments. Any req_i set → arbitrate, go OWN, aborting linger. Counter reaches LINGER_CYCLES-1 with no request → IDLE.
- grant_o never has more than one bit set. Granted requester may drop and re-raise req: it re-enters arbitration like any other requester.
- Counters are sized $clog2(limit+1) and never wrap.

## Timing
- Request sampled at edge t in IDLE/LINGER → grant_o, owner_o, num_o=data_i[winner]@t and blank_o=0 are all valid after edge t. Latency: 1 cycle.
- In OWN, num_o follows data_i[owner] with 1-cycle latency.
- Owner req low at edge t → grant_o=0 after edge t. Value is held for LINGER_CYCLES cycles, then blank_o=1 on the next edge.
- Simultaneous owner release and other request at edge t → direct OWN→OWN handoff to the rr winner. No LINGER, no blank cycle.
- rst_n low mid-operation: all outputs return to reset values immediately (async). Operation resumes on the first edge after rst_n rises.

## Configuration
- SEG7_ARB_PREEMPT_EN defined: in OWN, when tenure reaches MAX_HOLD and another req_i bit is set, grant moves to the rr winner (excluding current owner) in one cycle. Tenure clears on each grant. If no other request is pending, the owner keeps the display.
- Not defined: no tenure counter. Owner keeps the display until it drops req_i. MAX_HOLD is ignored.

## Structure
- Shared package seg7_pkg: state enum (IDLE/OWN/LINGER), digit count 8, nibble width 4, value width 32.
- Sub-module seg7_rr_pick: combinational round-robin picker (req vector, pointer, exclude mask → one-hot winner, index, valid).

## Test plan
- Reset → grant_o=0, num_o=0, blank_o=1. req_i=4'b0001, data_i[0]=32'h1234_5678 → after 1 edge: grant_o=4'b0001, num_o=32'h1234_5678, blank_o=0.
- req_i=4'b1111 held, each owner releasing after 3 cycles → grants in order 0,1,2,3,0 with no overlap and no blank cycles.
- LINGER_CYCLES=5, sole owner releases → grant_o=0 next cycle, num_o unchanged 5 cycles, then blank_o=1.
- During linger, req_i[2] rises with data 32'hDEAD_BEEF → grant_o=4'b0100, num_o=32'hDEAD_BEEF one edge later, linger aborted.
- SEG7_ARB_PREEMPT_EN with MAX_HOLD=10: owner 1 holds, req 3 raised → grant moves to 3 after 10 tenure cycles. Without the macro, owner 1 keeps grant for 100 cycles.
- rst_n pulsed low mid-OWN → outputs return to reset values asynchronously. First request after reset goes to requester 0 priority.
